divisor_prog: RTL and testbench
===============================

Name: divisor_prog

Overview:
- Parametrised, runtime-programmable clock divider and timing-tick generator for the Morse transmitter.
- Replaces the fixed 100 MHz to 0.5 Hz divider with a loadable terminal count and a one-cycle TICK strobe for synchronous consumers.
- Keeps a toggled CLK_2 output for legacy and LED use.
- Reloads of the divide value take effect only at a wrap boundary, so the output period never glitches.

Parameters:
- WIDTH, 28, counter and terminal-count width in bits.
- DEFAULT_DIV, 99999999, terminal count loaded at reset. Tick period is DEFAULT_DIV+1 cycles.
- UNIT_W, 3, width of the optional unit counter. Covers Morse units 0..7.

Ports:
- CLK  input  1  system clock (100 MHz).
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  count enable. 0 freezes the counter.
- DIV_IN  input  WIDTH  new terminal count.
- LOAD  input  1  one-cycle strobe; captures DIV_IN.
- LOAD_ACK  output  1  one-cycle pulse when the new terminal count becomes active.
- PEND  output  1  a captured value is waiting for a wrap.
- TICK  output  1  one-cycle strobe per period.
- CLK_2  output  1  toggles on every wrap; 50 % duty cycle, period 2*(tc+1).

Behaviour:
- Reset, asynchronous and immediate:
  - cnt=0, tc=DEFAULT_DIV, pend_val=0.
  - PEND=0, TICK=0, CLK_2=0, LOAD_ACK=0.
- Counting, EN=1:
  - If cnt==tc: cnt<=0, TICK<=1, CLK_2<=~CLK_2.
  - Otherwise: cnt<=cnt+1, TICK<=0.
  - All outputs are registered. TICK is high in the cycle after the wrap edge, i.e. while cnt==0.
  - Period is exactly tc+1 cycles.
- EN=0: cnt and CLK_2 hold; TICK=0.
- tc=0: divide-by-1. TICK is held high continuously and CLK_2 toggles every cycle.
- LOAD with EN=1:
  - pend_val<=DIV_IN, PEND<=1.
  - At the next wrap: tc<=pend_val, PEND<=0, LOAD_ACK<=1 for one cycle, registered alongside TICK.
  - The old period completes unchanged.
- LOAD while PEND=1: pend_val is overwritten; last write wins. Only one LOAD_ACK is issued.
- LOAD in the same cycle as a wrap: DIV_IN bypasses pend_val and becomes tc at that wrap. PEND stays 0 and LOAD_ACK pulses.
- LOAD or pending value with EN=0: applied on the next edge. tc<=value, cnt<=0, PEND<=0, LOAD_ACK pulses, CLK_2 unchanged, no TICK.
- Invariant: cnt<=tc at all times. tc only changes at a wrap or with cnt cleared, so there is no overshoot and no 2^WIDTH wrap-around.
- RST mid-period or with PEND=1: the pending value is discarded; tc returns to DEFAULT_DIV.
- Counter arithmetic is unsigned, WIDTH bits. The increment never overflows, by the invariant above.

Optional Feature:
- Macro: DIVISOR_UNIT_CNT_EN.
- Defined:
  - Adds input UNIT_CLR (1 bit) and output UNIT_CNT (UNIT_W bits). Reset value of UNIT_CNT is 0.
  - UNIT_CNT increments on each TICK and wraps modulo 2^UNIT_W. This lets the encoder time dot=1, dash=3, gap=7 units.
  - UNIT_CLR is synchronous and forces 0; it has priority over a simultaneous TICK increment.
- Undefined: those ports and that logic are absent; all other behaviour is identical.

Decomposition:
- Package divisor_pkg:
  - DIV_WIDTH=28.
  - DIV_1HZ=28'd99999999.
  - Morse unit constants UNIT_DOT=1, UNIT_DASH=3, UNIT_GAP=7.
- Sub-module contador_tc: WIDTH-bit counter with synchronous clear, enable, and terminal-compare output (the wrap flag).
- The load/pending logic, TICK/CLK_2 registers and the optional unit counter live in divisor_prog.

Test Plan:
- DEFAULT_DIV=4, EN=1 after reset → TICK every 5 cycles and CLK_2 period 10 cycles; all outputs 0 during RST.
- LOAD DIV_IN=2 at cnt=1 → PEND=1. The current period still ends after 5 cycles, then LOAD_ACK pulses with TICK and the period becomes 3 cycles.
- LOAD 7 then LOAD 1 before the wrap → a single LOAD_ACK; the period becomes 2 cycles.
- EN=0 at cnt=3 for 10 cycles → cnt holds, TICK stays 0, CLK_2 is stable. Then LOAD 0 → the next cycle has cnt=0 and LOAD_ACK; after EN=1, TICK is high every cycle.
- Assert RST asynchronously mid-count with PEND=1 → all outputs clear immediately, tc=4, PEND=0.
- With DIVISOR_UNIT_CNT_EN: after 9 TICKs with UNIT_W=3, UNIT_CNT=1. UNIT_CLR in the same cycle as a TICK gives UNIT_CNT=0.

Source files
------------

// File: rtl/divisor_pkg.sv
// Shared constants for the programmable Morse timing divider.
// Unit constants give the encoder's dot/dash/gap lengths in ticks.
package divisor_pkg;

    localparam int unsigned DIV_WIDTH = 28;
    localparam logic [DIV_WIDTH-1:0] DIV_1HZ = 28'd99999999;

    localparam int unsigned UNIT_DOT  = 1;
    localparam int unsigned UNIT_DASH = 3;
    localparam int unsigned UNIT_GAP  = 7;

endpackage

// File: rtl/contador_tc.sv
// WIDTH-bit up counter that returns to zero after reaching the terminal count.
// o_wrap flags cnt==tc; i_clr has priority over counting.
module contador_tc
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_tc,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;

    assign o_wrap = (r_cnt == i_tc);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_en) begin
            w_cnt_nxt = o_wrap ? '0 : r_cnt + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/divisor_prog.sv
// Runtime-programmable divider: TICK strobe, CLK_2 toggle, glitch-free terminal-count reload.
// Define DIVISOR_UNIT_CNT_EN to add the UNIT_CLR / UNIT_CNT Morse unit counter.
module divisor_prog
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH       = DIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = DIV_1HZ
`ifdef DIVISOR_UNIT_CNT_EN
    ,
    parameter int unsigned UNIT_W      = 3
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [WIDTH-1:0]  DIV_IN,
    input  logic              LOAD,
    output logic              LOAD_ACK,
    output logic              PEND,
    output logic              TICK,
    output logic              CLK_2
`ifdef DIVISOR_UNIT_CNT_EN
    ,
    input  logic              UNIT_CLR,
    output logic [UNIT_W-1:0] UNIT_CNT
`endif
);

    localparam logic [WIDTH-1:0] TC_RST = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] r_tc;
    logic [WIDTH-1:0] r_pend_val;
    logic             r_pend;
    logic             r_ack;
    logic             r_tick;
    logic             r_clk2;

    logic [WIDTH-1:0] w_tc_nxt;
    logic [WIDTH-1:0] w_pend_val_nxt;
    logic [WIDTH-1:0] w_new_tc;
    logic             w_pend_nxt;
    logic             w_ack_nxt;
    logic             w_tick_nxt;
    logic             w_clk2_nxt;
    logic             w_hit;
    logic             w_apply;
    logic             w_cnt_clr;

    contador_tc #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_en   (EN),
        .i_clr  (w_cnt_clr),
        .i_tc   (r_tc),
        .o_wrap (w_hit)
    );

    // A LOAD seen this cycle beats an older pending value (last write wins).
    assign w_apply  = LOAD | r_pend;
    assign w_new_tc = LOAD ? DIV_IN : r_pend_val;

    always_comb begin
        w_tc_nxt       = r_tc;
        w_pend_val_nxt = r_pend_val;
        w_pend_nxt     = r_pend;
        w_ack_nxt      = 1'b0;
        w_tick_nxt     = 1'b0;
        w_clk2_nxt     = r_clk2;
        w_cnt_clr      = 1'b0;
        if (EN) begin
            if (w_hit) begin
                w_tick_nxt = 1'b1;
                w_clk2_nxt = ~r_clk2;
                if (w_apply) begin
                    w_tc_nxt   = w_new_tc;
                    w_pend_nxt = 1'b0;
                    w_ack_nxt  = 1'b1;
                end
            end else if (LOAD) begin
                w_pend_val_nxt = DIV_IN;
                w_pend_nxt     = 1'b1;
            end
        end else if (w_apply) begin
            // Stopped counter: safe to switch now, restarting the period from zero.
            w_tc_nxt   = w_new_tc;
            w_pend_nxt = 1'b0;
            w_ack_nxt  = 1'b1;
            w_cnt_clr  = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tc       <= TC_RST;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_ack      <= 1'b0;
            r_tick     <= 1'b0;
            r_clk2     <= 1'b0;
        end else begin
            r_tc       <= w_tc_nxt;
            r_pend_val <= w_pend_val_nxt;
            r_pend     <= w_pend_nxt;
            r_ack      <= w_ack_nxt;
            r_tick     <= w_tick_nxt;
            r_clk2     <= w_clk2_nxt;
        end
    end

    assign LOAD_ACK = r_ack;
    assign PEND     = r_pend;
    assign TICK     = r_tick;
    assign CLK_2    = r_clk2;

`ifdef DIVISOR_UNIT_CNT_EN
    logic [UNIT_W-1:0] r_unit_cnt;

    // Counts TICK strobes as seen by consumers; clear wins over a coincident TICK.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_unit_cnt <= '0;
        end else if (UNIT_CLR) begin
            r_unit_cnt <= '0;
        end else if (r_tick) begin
            r_unit_cnt <= r_unit_cnt + UNIT_W'(1);
        end
    end

    assign UNIT_CNT = r_unit_cnt;
`endif

endmodule

// File: tb/tb_divisor_prog.sv
// Directed self-checking bench for divisor_prog with DEFAULT_DIV=4.
// Unit counter checks are included when DIVISOR_UNIT_CNT_EN is defined.
module tb_divisor_prog;

    localparam int unsigned WIDTH = 28;

    logic             CLK    = 1'b0;
    logic             RST    = 1'b1;
    logic             EN     = 1'b0;
    logic             LOAD   = 1'b0;
    logic [WIDTH-1:0] DIV_IN = '0;
    logic             LOAD_ACK;
    logic             PEND;
    logic             TICK;
    logic             CLK_2;
`ifdef DIVISOR_UNIT_CNT_EN
    logic             UNIT_CLR = 1'b0;
    logic [2:0]       UNIT_CNT;
`endif

    int   total    = 0;
    int   bad      = 0;
    logic exp_clk2 = 1'b0;

    always #5 CLK = ~CLK;

    divisor_prog #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (4)
`ifdef DIVISOR_UNIT_CNT_EN
        ,
        .UNIT_W      (3)
`endif
    ) u_dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .DIV_IN   (DIV_IN),
        .LOAD     (LOAD),
        .LOAD_ACK (LOAD_ACK),
        .PEND     (PEND),
        .TICK     (TICK),
        .CLK_2    (CLK_2)
`ifdef DIVISOR_UNIT_CNT_EN
        ,
        .UNIT_CLR (UNIT_CLR),
        .UNIT_CNT (UNIT_CNT)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".tick"}, 32'(TICK), 32'd0);
        chk({tag, ".clk2"}, 32'(CLK_2), 32'd0);
        chk({tag, ".ack"}, 32'(LOAD_ACK), 32'd0);
        chk({tag, ".pend"}, 32'(PEND), 32'd0);
    endtask

    // Apply inputs, clock once, then check every output against hand-derived values.
    task automatic cyc(input logic en, input logic ld, input logic [WIDTH-1:0] din,
                       input logic e_tick, input logic e_ack, input logic e_pend,
                       input string tag);
        EN     = en;
        LOAD   = ld;
        DIV_IN = din;
        @(posedge CLK);
        #1;
        if (e_tick) exp_clk2 = ~exp_clk2;
        chk({tag, ".tick"}, 32'(TICK), 32'(e_tick));
        chk({tag, ".clk2"}, 32'(CLK_2), 32'(exp_clk2));
        chk({tag, ".ack"}, 32'(LOAD_ACK), 32'(e_ack));
        chk({tag, ".pend"}, 32'(PEND), 32'(e_pend));
    endtask

    task automatic per(input int n, input string tag);
        for (int i = 1; i <= n; i++) begin
            cyc(1'b1, 1'b0, '0, (i == n), 1'b0, 1'b0, tag);
        end
    endtask

    initial begin
        // Reset: outputs low before and across a clock edge.
        #3;
        chk_all_zero("rst_pre");
        @(posedge CLK);
        #1;
        chk_all_zero("rst_edge");
        RST = 1'b0;

        // Default tc=4: TICK every 5 cycles, CLK_2 period 10.
        per(5, "def_p1");
        per(5, "def_p2");

        // LOAD 2 at cnt=1: old period finishes, then period 3.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "ld2_c1");
        cyc(1'b1, 1'b1, 28'd2, 1'b0, 1'b0, 1'b1, "ld2_cap");
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, "ld2_w1");
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, "ld2_w2");
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, "ld2_wrap");
        per(3, "p3_a");
        per(3, "p3_b");

        // LOAD 7 then LOAD 1 before the wrap: one ACK, period 2.
        cyc(1'b1, 1'b1, 28'd7, 1'b0, 1'b0, 1'b1, "ld7");
        cyc(1'b1, 1'b1, 28'd1, 1'b0, 1'b0, 1'b1, "ld1");
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b1, 1'b0, "ld1_wrap");
        per(2, "p2_a");
        per(2, "p2_b");

        // LOAD 4 in the wrap cycle bypasses pending and takes effect at once.
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "byp_c1");
        cyc(1'b1, 1'b1, 28'd4, 1'b1, 1'b1, 1'b0, "byp_wrap");

        // Run to cnt=3, freeze 10 cycles, then resume: wrap after 2 more edges.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "to_c3");
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "hold");
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "resume_c4");
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, "resume_wrap");

        // Back to cnt=3, stop, LOAD 0 while stopped: immediate ACK, no TICK.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "to_c3b");
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "stop");
        cyc(1'b0, 1'b1, 28'd0, 1'b0, 1'b1, 1'b0, "ld0_stopped");
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "ld0_after");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, "div1");

        // Reload 4 while stopped, then async reset mid-period with a value pending.
        cyc(1'b0, 1'b1, 28'd4, 1'b0, 1'b1, 1'b0, "ld4_stopped");
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "pre_rst_c1");
        cyc(1'b1, 1'b1, 28'd9, 1'b0, 1'b0, 1'b1, "pre_rst_pend");
        #2;
        RST = 1'b1;
        #1;
        chk_all_zero("rst_async");
        exp_clk2 = 1'b0;
        EN   = 1'b1;
        LOAD = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        per(5, "post_rst_p1");
        per(5, "post_rst_p2");

`ifdef DIVISOR_UNIT_CNT_EN
        // Fresh reset, then count 9 TICKs modulo 8 and check clear priority.
        RST = 1'b1;
        #1;
        chk("unit_rst", 32'(UNIT_CNT), 32'd0);
        exp_clk2 = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 9; i++) per(5, "unit_run");
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "unit_after9");
        chk("unit_9ticks", 32'(UNIT_CNT), 32'd1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "unit_idle");
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0, "unit_tick10");
        UNIT_CLR = 1'b1;
        cyc(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, "unit_clr_edge");
        chk("unit_clr_prio", 32'(UNIT_CNT), 32'd0);
        UNIT_CLR = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
